// File: rtl/booth_pp_accum.sv
// -----------------------------------------------------------------------------
// booth_pp_accum
//
// Sums the four radix-4 Booth partial products of an 8x8 multiply at their
// bit weights and hands the 16-bit product downstream. A single shared adder
// folds in one partial product per cycle (SINGLE_CYCLE=0, latency 4), or all
// four are summed in the capture cycle (SINGLE_CYCLE=1, latency 1). The
// valid/ready behaviour is the same in both modes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   partial-product set valid
//   in_ready   block can accept a set (high only in IDLE, registered)
//   pp0        partial product 0, weight bits [11:0]
//   pp1        partial product 1, weight bits [12:2]
//   pp2        partial product 2, weight bits [14:4]
//   pp3        partial product 3, weight bits [15:6]
//   out_valid  product valid (high only in DONE, registered)
//   out_ready  downstream accepts product
//   product    accumulated product, mod 2^16 (registered)
//   busy       high in any state other than IDLE (registered)
// -----------------------------------------------------------------------------
module booth_pp_accum #(
  parameter bit SINGLE_CYCLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] pp0,
  input  logic [10:0] pp1,
  input  logic [10:0] pp2,
  input  logic [9:0]  pp3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    ACC1,
    ACC2,
    ACC3,
    DONE
  } state_e;

  state_e      state_q;
  logic [10:0] pp1_q;
  logic [10:0] pp2_q;
  logic [9:0]  pp3_q;
  logic [15:0] acc_q;
  logic [15:0] product_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  logic [15:0] addend_d;
  logic [15:0] acc_sum_d;
  logic [15:0] full_sum_d;

  // Operand for the shared adder: the captured partial product for the
  // current accumulation step, already shifted to its weight.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    addend_d = '0;
    case (state_q)
      ACC1:    addend_d = {3'b000, pp1_q, 2'b00};
      ACC2:    addend_d = {1'b0, pp2_q, 4'b0000};
      ACC3:    addend_d = {pp3_q, 6'b000000};
      default: addend_d = '0;
    endcase
  end

  // Carries out of bit 15 fall off the 16-bit result.
  assign acc_sum_d  = acc_q + addend_d;

  // Full sum straight from the ports, used only when SINGLE_CYCLE=1.
  assign full_sum_d = {4'b0000, pp0}
                    + {3'b000, pp1, 2'b00}
                    + {1'b0, pp2, 4'b0000}
                    + {pp3, 6'b000000};

  // Control FSM with registered handshake outputs. The partial products are
  // latched at capture so later input changes cannot disturb the result.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pp1_q       <= '0;
      pp2_q       <= '0;
      pp3_q       <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            pp1_q      <= pp1;
            pp2_q      <= pp2;
            pp3_q      <= pp3;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (SINGLE_CYCLE) begin
              acc_q       <= full_sum_d;
              product_q   <= full_sum_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              acc_q   <= {4'b0000, pp0};
              state_q <= ACC1;
            end
          end
        end
        ACC1: begin
          acc_q   <= acc_sum_d;
          state_q <= ACC2;
        end
        ACC2: begin
          acc_q   <= acc_sum_d;
          state_q <= ACC3;
        end
        ACC3: begin
          acc_q       <= acc_sum_d;
          product_q   <= acc_sum_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // Hold product and out_valid until downstream takes the result.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_pp_accum.sv
// -----------------------------------------------------------------------------
// tb_booth_pp_accum
//
// Directed bench for booth_pp_accum. Two instances share clock, reset,
// partial-product inputs and out_ready: dut0 runs the four-cycle accumulator
// (SINGLE_CYCLE=0), dut1 the single-cycle sum (SINGLE_CYCLE=1). Each has
// its own in_valid so only one is exercised at a time. Inputs change and
// outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_booth_pp_accum;

  logic        clk;
  logic        rst;
  logic        in_valid0;
  logic        in_valid1;
  logic [11:0] pp0;
  logic [10:0] pp1;
  logic [10:0] pp2;
  logic [9:0]  pp3;
  logic        out_ready;

  logic        in_ready0,  in_ready1;
  logic        out_valid0, out_valid1;
  logic [15:0] product0,   product1;
  logic        busy0,      busy1;

  int tests_run;
  int tests_failed;

  booth_pp_accum #(.SINGLE_CYCLE(1'b0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid0),
    .in_ready (in_ready0),
    .pp0      (pp0),
    .pp1      (pp1),
    .pp2      (pp2),
    .pp3      (pp3),
    .out_valid(out_valid0),
    .out_ready(out_ready),
    .product  (product0),
    .busy     (busy0)
  );

  booth_pp_accum #(.SINGLE_CYCLE(1'b1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .pp0      (pp0),
    .pp1      (pp1),
    .pp2      (pp2),
    .pp3      (pp3),
    .out_valid(out_valid1),
    .out_ready(out_ready),
    .product  (product1),
    .busy     (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pp(input logic [11:0] a, input logic [10:0] b,
                        input logic [10:0] c, input logic [9:0] d);
    pp0 = a;
    pp1 = b;
    pp2 = c;
    pp3 = d;
  endtask

  // Mode-0 transaction with out_ready as set by the caller: handshake edge T,
  // out_valid must be low after T, T+1, T+2 and high after T+3.
  task automatic run0(input string tag, input logic [15:0] exp_product);
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    check({tag, " busy after capture"}, 32'(busy0), 32'd1);
    check({tag, " in_ready after capture"}, 32'(in_ready0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check({tag, " out_valid early"}, 32'(out_valid0), 32'd0);
      tick();
    end
    check({tag, " out_valid"}, 32'(out_valid0), 32'd1);
    check({tag, " product"}, 32'(product0), 32'(exp_product));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    out_ready = 1'b1;
    set_pp(12'h000, 11'h000, 11'h000, 10'h000);

    // Reset state of both instances.
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready0", 32'(in_ready0), 32'd1);
    check("reset out_valid0", 32'(out_valid0), 32'd0);
    check("reset product0", 32'(product0), 32'h0);
    check("reset busy0", 32'(busy0), 32'd0);
    check("reset in_ready1", 32'(in_ready1), 32'd1);
    check("reset out_valid1", 32'(out_valid1), 32'd0);
    check("reset busy1", 32'(busy1), 32'd0);

    // All ones in the LSB of each partial product: 1+4+16+64 = 0x55.
    set_pp(12'h001, 11'h001, 11'h001, 10'h001);
    run0("ones", 16'h0055);
    tick();
    check("ones out_valid drop", 32'(out_valid0), 32'd0);
    check("ones in_ready back", 32'(in_ready0), 32'd1);
    check("ones busy drop", 32'(busy0), 32'd0);
    check("ones product held", 32'(product0), 32'h0055);

    // Wrap-around: 0xFFF+0x1FFC+0x7FF0+0xFFC0 = 0x1AFAB, carry dropped.
    set_pp(12'hFFF, 11'h7FF, 11'h7FF, 10'h3FF);
    run0("wrap", 16'hAFAB);
    tick();

    // Backpressure: hold DONE for 10 cycles while a new set waits on in_valid.
    out_ready = 1'b0;
    set_pp(12'h001, 11'h001, 11'h001, 10'h001);
    run0("bp", 16'h0055);
    set_pp(12'h003, 11'h000, 11'h000, 10'h000);
    in_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp out_valid held", 32'(out_valid0), 32'd1);
      check("bp product held", 32'(product0), 32'h0055);
      check("bp in_ready low", 32'(in_ready0), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp release out_valid", 32'(out_valid0), 32'd0);
    check("bp release in_ready", 32'(in_ready0), 32'd1);
    // in_valid has stayed high; this edge performs the capture.
    run0("bp queued", 16'h0003);
    tick();

    // Inputs changed during ACC1 must not affect the captured set.
    set_pp(12'h010, 11'h000, 11'h000, 10'h000);
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    pp1 = 11'h7FF;
    pp2 = 11'h7FF;
    pp3 = 10'h3FF;
    tick();
    tick();
    tick();
    check("late change out_valid", 32'(out_valid0), 32'd1);
    check("late change product", 32'(product0), 32'h0010);
    tick();

    // Reset in ACC2 aborts the set; it must never be presented.
    set_pp(12'h001, 11'h001, 11'h001, 10'h001);
    in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort in_ready", 32'(in_ready0), 32'd1);
    check("abort busy", 32'(busy0), 32'd0);
    check("abort product cleared", 32'(product0), 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("abort out_valid", 32'(out_valid0), 32'd0);
      tick();
    end
    set_pp(12'h002, 11'h000, 11'h000, 10'h000);
    run0("after abort", 16'h0002);
    tick();

    // Single-cycle mode: result one cycle after the handshake, back-to-back
    // sets accepted every two cycles.
    set_pp(12'h001, 11'h001, 11'h001, 10'h001);
    in_valid1 = 1'b1;
    tick();
    check("sc ones out_valid", 32'(out_valid1), 32'd1);
    check("sc ones product", 32'(product1), 32'h0055);
    check("sc ones in_ready", 32'(in_ready1), 32'd0);
    check("sc ones busy", 32'(busy1), 32'd1);
    set_pp(12'hFFF, 11'h7FF, 11'h7FF, 10'h3FF);
    tick();
    check("sc gap out_valid", 32'(out_valid1), 32'd0);
    check("sc gap in_ready", 32'(in_ready1), 32'd1);
    tick();
    in_valid1 = 1'b0;
    check("sc wrap out_valid", 32'(out_valid1), 32'd1);
    check("sc wrap product", 32'(product1), 32'hAFAB);
    tick();
    check("sc idle out_valid", 32'(out_valid1), 32'd0);

    // Reset together with in_valid: nothing is captured.
    set_pp(12'h007, 11'h000, 11'h000, 10'h000);
    rst       = 1'b1;
    in_valid1 = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid1 = 1'b0;
    check("rst+valid in_ready", 32'(in_ready1), 32'd1);
    check("rst+valid busy", 32'(busy1), 32'd0);
    tick();
    check("rst+valid out_valid", 32'(out_valid1), 32'd0);
    check("rst+valid product", 32'(product1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
